// File: rtl/sifs_responder.sv
// sifs_responder: schedules an ACK or CTS response one SIFS after the end of a
// correctly received frame addressed to this station.
//
// Ports
//   clk, rstn                 clock, asynchronous active-low reset
//   tsf_pulse_1M              one-cycle pulse every microsecond
//   pkt_header_valid_strobe,
//   pkt_header_valid          start of a received frame and whether it is usable
//   FC_DI_valid, FC_type,
//   FC_subtype, duration      frame-control / duration strobe and fields
//   addr1_valid, addr1,
//   addr2_valid, addr2        receiver / transmitter address strobes and values
//   self_mac_addr             own MAC address
//   fcs_in_strobe, fcs_valid  end of frame and CRC result
//   resp_enable               0 blocks new responses
//   sifs_time, resp_time      SIFS and response airtime in microseconds
//   resp_req, resp_ack        request to the tx engine and its acceptance
//   resp_type                 0 = ACK, 1 = CTS
//   resp_ra, resp_duration    response RA and duration field
//   resp_pending              response scheduled (SIFS wait or request)
//   resp_drop                 one-cycle pulse when a scheduled response is abandoned
//   resp_count                number of responses accepted by the tx engine
module sifs_responder #(
  parameter int unsigned TX_GRANT_TIMEOUT_US = 8
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        tsf_pulse_1M,
  input  logic        pkt_header_valid_strobe,
  input  logic        pkt_header_valid,
  input  logic        FC_DI_valid,
  input  logic [1:0]  FC_type,
  input  logic [3:0]  FC_subtype,
  input  logic [15:0] duration,
  input  logic        addr1_valid,
  input  logic [47:0] addr1,
  input  logic        addr2_valid,
  input  logic [47:0] addr2,
  input  logic [47:0] self_mac_addr,
  input  logic        fcs_in_strobe,
  input  logic        fcs_valid,
  input  logic        resp_enable,
  input  logic [6:0]  sifs_time,
  input  logic [7:0]  resp_time,
  output logic        resp_req,
  input  logic        resp_ack,
  output logic        resp_type,
  output logic [47:0] resp_ra,
  output logic [15:0] resp_duration,
  output logic        resp_pending,
  output logic        resp_drop,
  output logic [15:0] resp_count
);

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    WAIT_FCS,
    SIFS,
    REQ
  } state_e;

  // Value of the grant counter on which the next microsecond pulse times out.
  localparam logic [15:0] TO_LAST = 16'(TX_GRANT_TIMEOUT_US - 1);

  state_e      state_q, state_d;
  logic        fc_seen_q, fc_seen_d;
  logic [1:0]  type_q, type_d;
  logic [3:0]  subtype_q, subtype_d;
  logic [15:0] dur_q, dur_d;
  logic        ra_seen_q, ra_seen_d;
  logic        ra_match_q, ra_match_d;
  logic        ta_seen_q, ta_seen_d;
  logic [47:0] ta_q, ta_d;
  logic [6:0]  sifs_cnt_q, sifs_cnt_d;
  logic [15:0] to_cnt_q, to_cnt_d;
  logic        rtype_q, rtype_d;
  logic [47:0] rra_q, rra_d;
  logic [15:0] rdur_q, rdur_d;
  logic        drop_q, drop_d;
  logic [15:0] count_q, count_d;

  logic        is_ack, is_cts, eligible;
  logic [16:0] overhead, dur_ext, dur_diff;
  logic [15:0] rdur_calc;

  // Eligibility and response duration are evaluated from the latched fields
  // only, so a field strobe coinciding with the FCS strobe does not count.
  always_comb begin
    is_ack    = (type_q == 2'b00) || (type_q == 2'b10);
    is_cts    = (type_q == 2'b01) && (subtype_q == 4'b1011) && !dur_q[15];
    eligible  = fc_seen_q && ra_seen_q && ta_seen_q && ra_match_q &&
                resp_enable && fcs_valid && (is_ack || is_cts);
    overhead  = {10'd0, sifs_time} + {9'd0, resp_time};
    dur_ext   = {1'b0, dur_q};
    dur_diff  = dur_ext - overhead;
    rdur_calc = (!dur_q[15] && (dur_ext > overhead)) ? dur_diff[15:0] : '0;
  end

  always_comb begin
    state_d    = state_q;
    fc_seen_d  = fc_seen_q;
    type_d     = type_q;
    subtype_d  = subtype_q;
    dur_d      = dur_q;
    ra_seen_d  = ra_seen_q;
    ra_match_d = ra_match_q;
    ta_seen_d  = ta_seen_q;
    ta_d       = ta_q;
    sifs_cnt_d = sifs_cnt_q;
    to_cnt_d   = to_cnt_q;
    rtype_d    = rtype_q;
    rra_d      = rra_q;
    rdur_d     = rdur_q;
    drop_d     = 1'b0;
    count_d    = count_q;

    unique case (state_q)
      IDLE, CAPTURE, WAIT_FCS: begin
        if (pkt_header_valid_strobe) begin
          state_d    = pkt_header_valid ? CAPTURE : IDLE;
          fc_seen_d  = 1'b0;
          type_d     = '0;
          subtype_d  = '0;
          dur_d      = '0;
          ra_seen_d  = 1'b0;
          ra_match_d = 1'b0;
          ta_seen_d  = 1'b0;
          ta_d       = '0;
        end else if ((state_q != IDLE) && fcs_in_strobe) begin
          if (eligible) begin
            state_d    = SIFS;
            sifs_cnt_d = sifs_time;
            rtype_d    = is_cts;
            rra_d      = ta_q;
            rdur_d     = rdur_calc;
          end else begin
            state_d = IDLE;
          end
        end else if (state_q == CAPTURE) begin
          if (FC_DI_valid) begin
            fc_seen_d = 1'b1;
            type_d    = FC_type;
            subtype_d = FC_subtype;
            dur_d     = duration;
          end
          if (addr1_valid) begin
            ra_seen_d  = 1'b1;
            ra_match_d = (addr1 == self_mac_addr);
          end
          if (addr2_valid) begin
            ta_seen_d = 1'b1;
            ta_d      = addr2;
          end
          if (fc_seen_d && ra_seen_d && ta_seen_d) begin
            state_d = WAIT_FCS;
          end
        end
      end

      SIFS: begin
        if (pkt_header_valid_strobe) begin
          state_d = IDLE;
          drop_d  = 1'b1;
        end else if (sifs_cnt_q == '0) begin
          state_d  = REQ;
          to_cnt_d = '0;
        end else if (tsf_pulse_1M) begin
          sifs_cnt_d = sifs_cnt_q - 7'd1;
        end
      end

      REQ: begin
        // A grant on the timeout pulse still wins.
        if (resp_ack) begin
          state_d = IDLE;
          count_d = count_q + 16'd1;
        end else if (tsf_pulse_1M) begin
          if (to_cnt_q == TO_LAST) begin
            state_d = IDLE;
            drop_d  = 1'b1;
          end else begin
            to_cnt_d = to_cnt_q + 16'd1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      fc_seen_q  <= 1'b0;
      type_q     <= '0;
      subtype_q  <= '0;
      dur_q      <= '0;
      ra_seen_q  <= 1'b0;
      ra_match_q <= 1'b0;
      ta_seen_q  <= 1'b0;
      ta_q       <= '0;
      sifs_cnt_q <= '0;
      to_cnt_q   <= '0;
      rtype_q    <= 1'b0;
      rra_q      <= '0;
      rdur_q     <= '0;
      drop_q     <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fc_seen_q  <= fc_seen_d;
      type_q     <= type_d;
      subtype_q  <= subtype_d;
      dur_q      <= dur_d;
      ra_seen_q  <= ra_seen_d;
      ra_match_q <= ra_match_d;
      ta_seen_q  <= ta_seen_d;
      ta_q       <= ta_d;
      sifs_cnt_q <= sifs_cnt_d;
      to_cnt_q   <= to_cnt_d;
      rtype_q    <= rtype_d;
      rra_q      <= rra_d;
      rdur_q     <= rdur_d;
      drop_q     <= drop_d;
      count_q    <= count_d;
    end
  end

  assign resp_req      = (state_q == REQ);
  assign resp_pending  = (state_q == SIFS) || (state_q == REQ);
  assign resp_type     = rtype_q;
  assign resp_ra       = rra_q;
  assign resp_duration = rdur_q;
  assign resp_drop     = drop_q;
  assign resp_count    = count_q;

endmodule

// File: tb/tb_sifs_responder.sv
// Directed testbench for sifs_responder: one task per scenario, inline checks.
module tb_sifs_responder;

  logic        clk;
  logic        rstn;
  logic        tsf_pulse_1M;
  logic        pkt_header_valid_strobe, pkt_header_valid;
  logic        FC_DI_valid;
  logic [1:0]  FC_type;
  logic [3:0]  FC_subtype;
  logic [15:0] duration;
  logic        addr1_valid, addr2_valid;
  logic [47:0] addr1, addr2, self_mac_addr;
  logic        fcs_in_strobe, fcs_valid, resp_enable;
  logic [6:0]  sifs_time;
  logic [7:0]  resp_time;
  logic        resp_req, resp_ack, resp_type, resp_pending, resp_drop;
  logic [47:0] resp_ra;
  logic [15:0] resp_duration, resp_count;

  int unsigned pass_cnt  = 0;
  int unsigned total_cnt = 0;
  logic [15:0] exp_count = '0;

  localparam logic [47:0] SELF  = 48'h02_11_22_33_44_55;
  localparam logic [47:0] STA_A = 48'h0A_0B_0C_0D_0E_0F;
  localparam logic [47:0] STA_B = 48'h06_AA_BB_CC_DD_EE;
  localparam logic [47:0] OTHER = 48'h02_11_22_33_44_56;

  sifs_responder #(.TX_GRANT_TIMEOUT_US(8)) dut (
    .clk(clk), .rstn(rstn), .tsf_pulse_1M(tsf_pulse_1M),
    .pkt_header_valid_strobe(pkt_header_valid_strobe), .pkt_header_valid(pkt_header_valid),
    .FC_DI_valid(FC_DI_valid), .FC_type(FC_type), .FC_subtype(FC_subtype), .duration(duration),
    .addr1_valid(addr1_valid), .addr1(addr1), .addr2_valid(addr2_valid), .addr2(addr2),
    .self_mac_addr(self_mac_addr), .fcs_in_strobe(fcs_in_strobe), .fcs_valid(fcs_valid),
    .resp_enable(resp_enable), .sifs_time(sifs_time), .resp_time(resp_time),
    .resp_req(resp_req), .resp_ack(resp_ack), .resp_type(resp_type), .resp_ra(resp_ra),
    .resp_duration(resp_duration), .resp_pending(resp_pending), .resp_drop(resp_drop),
    .resp_count(resp_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One microsecond: a tsf pulse cycle followed by three quiet cycles.
  task automatic tick();
    tsf_pulse_1M = 1'b1;
    step();
    tsf_pulse_1M = 1'b0;
    step();
    step();
    step();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic hdr(input logic v);
    pkt_header_valid_strobe = 1'b1;
    pkt_header_valid        = v;
    step();
    pkt_header_valid_strobe = 1'b0;
    pkt_header_valid        = 1'b0;
  endtask

  task automatic pulse_ack();
    resp_ack = 1'b1;
    step();
    resp_ack = 1'b0;
  endtask

  // Full received frame; returns one cycle after the FCS strobe edge.
  task automatic rx_frame(input logic [1:0] t, input logic [3:0] st, input logic [15:0] d,
                          input logic [47:0] a1, input logic [47:0] a2, input logic ok);
    hdr(1'b1);
    FC_DI_valid = 1'b1; FC_type = t; FC_subtype = st; duration = d;
    step();
    FC_DI_valid = 1'b0;
    addr1_valid = 1'b1; addr1 = a1;
    step();
    addr1_valid = 1'b0;
    addr2_valid = 1'b1; addr2 = a2;
    step();
    addr2_valid = 1'b0;
    fcs_in_strobe = 1'b1; fcs_valid = ok;
    step();
    fcs_in_strobe = 1'b0; fcs_valid = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    #12;
    total_cnt++; if ({resp_req, resp_type, resp_pending, resp_drop} !== 4'b0000)
      $display("FAIL reset_flags: got %b required 0000", {resp_req, resp_type, resp_pending, resp_drop}); else pass_cnt++;
    total_cnt++; if (resp_ra !== 48'd0) $display("FAIL reset_ra: got %h required 0", resp_ra); else pass_cnt++;
    total_cnt++; if (resp_duration !== 16'd0) $display("FAIL reset_dur: got %0d required 0", resp_duration); else pass_cnt++;
    total_cnt++; if (resp_count !== 16'd0) $display("FAIL reset_count: got %0d required 0", resp_count); else pass_cnt++;
    @(negedge clk);
    rstn = 1'b1;
    step();
    step();
  endtask

  task automatic test_ack_data();
    rx_frame(2'b10, 4'b0000, 16'd100, SELF, STA_A, 1'b1);
    total_cnt++; if ({resp_pending, resp_req} !== 2'b10) $display("FAIL ack_sifs_entry: got pend/req %b required 10", {resp_pending, resp_req}); else pass_cnt++;
    total_cnt++; if (resp_type !== 1'b0) $display("FAIL ack_type: got %0b required 0", resp_type); else pass_cnt++;
    total_cnt++; if (resp_ra !== STA_A) $display("FAIL ack_ra: got %h required %h", resp_ra, STA_A); else pass_cnt++;
    total_cnt++; if (resp_duration !== 16'd40) $display("FAIL ack_dur: got %0d required 40", resp_duration); else pass_cnt++;
    ticks(15);
    total_cnt++; if ({resp_pending, resp_req} !== 2'b10) $display("FAIL ack_15us: got pend/req %b required 10", {resp_pending, resp_req}); else pass_cnt++;
    tick();
    total_cnt++; if ({resp_pending, resp_req} !== 2'b11) $display("FAIL ack_16us_req: got pend/req %b required 11", {resp_pending, resp_req}); else pass_cnt++;
    total_cnt++; if (resp_duration !== 16'd40) $display("FAIL ack_dur_stable: got %0d required 40", resp_duration); else pass_cnt++;
    pulse_ack();
    exp_count++;
    total_cnt++; if ({resp_pending, resp_req, resp_drop} !== 3'b000) $display("FAIL ack_done: got pend/req/drop %b required 000", {resp_pending, resp_req, resp_drop}); else pass_cnt++;
    total_cnt++; if (resp_count !== exp_count) $display("FAIL ack_count: got %0d required %0d", resp_count, exp_count); else pass_cnt++;
  endtask

  task automatic test_cts_saturate();
    rx_frame(2'b01, 4'b1011, 16'd30, SELF, STA_B, 1'b1);
    total_cnt++; if ({resp_pending, resp_type} !== 2'b11) $display("FAIL cts_entry: got pend/type %b required 11", {resp_pending, resp_type}); else pass_cnt++;
    total_cnt++; if (resp_duration !== 16'd0) $display("FAIL cts_sat_dur: got %0d required 0", resp_duration); else pass_cnt++;
    total_cnt++; if (resp_ra !== STA_B) $display("FAIL cts_ra: got %h required %h", resp_ra, STA_B); else pass_cnt++;
    ticks(16);
    total_cnt++; if (resp_req !== 1'b1) $display("FAIL cts_req: got %0b required 1", resp_req); else pass_cnt++;
    pulse_ack();
    exp_count++;
    total_cnt++; if (resp_count !== exp_count) $display("FAIL cts_count: got %0d required %0d", resp_count, exp_count); else pass_cnt++;
  endtask

  task automatic test_ineligible();
    rx_frame(2'b10, 4'b0000, 16'd100, OTHER, STA_A, 1'b1);
    total_cnt++; if (resp_pending !== 1'b0) $display("FAIL inel_ra: got pend %0b required 0", resp_pending); else pass_cnt++;
    ticks(20);
    total_cnt++; if ({resp_pending, resp_req} !== 2'b00) $display("FAIL inel_ra_later: got pend/req %b required 00", {resp_pending, resp_req}); else pass_cnt++;
    rx_frame(2'b10, 4'b0000, 16'd100, SELF, STA_A, 1'b0);
    total_cnt++; if (resp_pending !== 1'b0) $display("FAIL inel_fcs: got pend %0b required 0", resp_pending); else pass_cnt++;
    resp_enable = 1'b0;
    rx_frame(2'b10, 4'b0000, 16'd100, SELF, STA_A, 1'b1);
    resp_enable = 1'b1;
    total_cnt++; if (resp_pending !== 1'b0) $display("FAIL inel_disabled: got pend %0b required 0", resp_pending); else pass_cnt++;
    rx_frame(2'b01, 4'b1011, 16'h8010, SELF, STA_A, 1'b1);
    total_cnt++; if (resp_pending !== 1'b0) $display("FAIL inel_rts_dur15: got pend %0b required 0", resp_pending); else pass_cnt++;
    rx_frame(2'b01, 4'b1101, 16'd0, SELF, STA_A, 1'b1);
    total_cnt++; if (resp_pending !== 1'b0) $display("FAIL inel_ctrl_ack: got pend %0b required 0", resp_pending); else pass_cnt++;
    rx_frame(2'b11, 4'b0000, 16'd100, SELF, STA_A, 1'b1);
    total_cnt++; if (resp_pending !== 1'b0) $display("FAIL inel_type3: got pend %0b required 0", resp_pending); else pass_cnt++;
    // FCS arrives before the addresses were seen.
    hdr(1'b1);
    FC_DI_valid = 1'b1; FC_type = 2'b10; FC_subtype = 4'b0000; duration = 16'd100;
    step();
    FC_DI_valid = 1'b0;
    fcs_in_strobe = 1'b1; fcs_valid = 1'b1;
    step();
    fcs_in_strobe = 1'b0; fcs_valid = 1'b0;
    total_cnt++; if (resp_pending !== 1'b0) $display("FAIL inel_missing: got pend %0b required 0", resp_pending); else pass_cnt++;
  endtask

  task automatic test_sifs_abort();
    rx_frame(2'b10, 4'b0000, 16'd100, SELF, STA_A, 1'b1);
    ticks(5);
    hdr(1'b1);
    total_cnt++; if ({resp_drop, resp_pending, resp_req} !== 3'b100) $display("FAIL abort_drop: got drop/pend/req %b required 100", {resp_drop, resp_pending, resp_req}); else pass_cnt++;
    step();
    total_cnt++; if (resp_drop !== 1'b0) $display("FAIL abort_drop_width: got %0b required 0", resp_drop); else pass_cnt++;
    ticks(20);
    total_cnt++; if ({resp_pending, resp_req} !== 2'b00) $display("FAIL abort_no_req: got pend/req %b required 00", {resp_pending, resp_req}); else pass_cnt++;
    total_cnt++; if (resp_count !== exp_count) $display("FAIL abort_count: got %0d required %0d", resp_count, exp_count); else pass_cnt++;
    // Invalid header also aborts; duration with bit 15 set yields 0.
    rx_frame(2'b10, 4'b0000, 16'h8010, SELF, STA_A, 1'b1);
    total_cnt++; if ({resp_pending, resp_duration} !== {1'b1, 16'd0}) $display("FAIL dur15_ack: got pend %0b dur %0d required 1 0", resp_pending, resp_duration); else pass_cnt++;
    hdr(1'b0);
    total_cnt++; if ({resp_drop, resp_pending} !== 2'b10) $display("FAIL abort_invalid_hdr: got drop/pend %b required 10", {resp_drop, resp_pending}); else pass_cnt++;
    step();
  endtask

  task automatic test_timeout();
    rx_frame(2'b10, 4'b0000, 16'd100, SELF, STA_A, 1'b1);
    ticks(16);
    ticks(7);
    total_cnt++; if ({resp_req, resp_drop} !== 2'b10) $display("FAIL to_7us: got req/drop %b required 10", {resp_req, resp_drop}); else pass_cnt++;
    tsf_pulse_1M = 1'b1;
    step();
    tsf_pulse_1M = 1'b0;
    total_cnt++; if ({resp_req, resp_drop, resp_pending} !== 3'b010) $display("FAIL to_drop: got req/drop/pend %b required 010", {resp_req, resp_drop, resp_pending}); else pass_cnt++;
    step();
    total_cnt++; if (resp_drop !== 1'b0) $display("FAIL to_drop_width: got %0b required 0", resp_drop); else pass_cnt++;
    total_cnt++; if (resp_count !== exp_count) $display("FAIL to_count: got %0d required %0d", resp_count, exp_count); else pass_cnt++;
    // Grant on the timeout pulse.
    rx_frame(2'b10, 4'b0000, 16'd100, SELF, STA_A, 1'b1);
    ticks(16);
    ticks(7);
    tsf_pulse_1M = 1'b1;
    resp_ack     = 1'b1;
    step();
    tsf_pulse_1M = 1'b0;
    resp_ack     = 1'b0;
    exp_count++;
    total_cnt++; if ({resp_req, resp_drop} !== 2'b00) $display("FAIL to_ack_wins: got req/drop %b required 00", {resp_req, resp_drop}); else pass_cnt++;
    total_cnt++; if (resp_count !== exp_count) $display("FAIL to_ack_count: got %0d required %0d", resp_count, exp_count); else pass_cnt++;
  endtask

  task automatic test_zero_sifs_and_enable();
    sifs_time = 7'd0;
    rx_frame(2'b00, 4'b0100, 16'd100, SELF, STA_B, 1'b1);
    total_cnt++; if ({resp_pending, resp_req} !== 2'b10) $display("FAIL zs_entry: got pend/req %b required 10", {resp_pending, resp_req}); else pass_cnt++;
    total_cnt++; if (resp_duration !== 16'd56) $display("FAIL zs_dur: got %0d required 56", resp_duration); else pass_cnt++;
    step();
    total_cnt++; if (resp_req !== 1'b1) $display("FAIL zs_req: got %0b required 1", resp_req); else pass_cnt++;
    pulse_ack();
    exp_count++;
    sifs_time = 7'd16;
    // Disabling after scheduling keeps the response.
    rx_frame(2'b10, 4'b0000, 16'd500, SELF, STA_A, 1'b1);
    resp_enable = 1'b0;
    ticks(16);
    total_cnt++; if ({resp_req, resp_duration} !== {1'b1, 16'd440}) $display("FAIL en_keep: got req %0b dur %0d required 1 440", resp_req, resp_duration); else pass_cnt++;
    pulse_ack();
    exp_count++;
    resp_enable = 1'b1;
    total_cnt++; if (resp_count !== exp_count) $display("FAIL en_count: got %0d required %0d", resp_count, exp_count); else pass_cnt++;
    pulse_ack();
    total_cnt++; if (resp_count !== exp_count) $display("FAIL idle_ack_ignored: got %0d required %0d", resp_count, exp_count); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    rx_frame(2'b01, 4'b1011, 16'd500, SELF, STA_B, 1'b1);
    ticks(16);
    hdr(1'b1);
    total_cnt++; if ({resp_req, resp_drop} !== 2'b10) $display("FAIL b2b_hdr_in_req: got req/drop %b required 10", {resp_req, resp_drop}); else pass_cnt++;
    total_cnt++; if ({resp_type, resp_duration} !== {1'b1, 16'd440}) $display("FAIL b2b_cts: got type %0b dur %0d required 1 440", resp_type, resp_duration); else pass_cnt++;
    pulse_ack();
    exp_count++;
    rx_frame(2'b10, 4'b0000, 16'd61, SELF, STA_A, 1'b1);
    total_cnt++; if ({resp_pending, resp_type, resp_ra, resp_duration} !== {2'b10, STA_A, 16'd1})
      $display("FAIL b2b_second: got pend %0b type %0b ra %h dur %0d required 1 0 %h 1", resp_pending, resp_type, resp_ra, resp_duration, STA_A); else pass_cnt++;
    ticks(16);
    pulse_ack();
    exp_count++;
    total_cnt++; if (resp_count !== exp_count) $display("FAIL b2b_count: got %0d required %0d", resp_count, exp_count); else pass_cnt++;
  endtask

  task automatic test_reset_in_req();
    rx_frame(2'b01, 4'b1011, 16'd500, SELF, STA_B, 1'b1);
    ticks(16);
    total_cnt++; if (resp_req !== 1'b1) $display("FAIL rst_pre_req: got %0b required 1", resp_req); else pass_cnt++;
    rstn = 1'b0;
    #2;
    total_cnt++; if ({resp_req, resp_type, resp_pending, resp_drop} !== 4'b0000)
      $display("FAIL rst_async_flags: got %b required 0000", {resp_req, resp_type, resp_pending, resp_drop}); else pass_cnt++;
    total_cnt++; if ({resp_ra, resp_duration, resp_count} !== 80'd0)
      $display("FAIL rst_async_data: got ra %h dur %0d cnt %0d required 0 0 0", resp_ra, resp_duration, resp_count); else pass_cnt++;
    step();
    rstn = 1'b1;
    step();
    total_cnt++; if ({resp_req, resp_pending, resp_drop} !== 3'b000) $display("FAIL rst_after: got req/pend/drop %b required 000", {resp_req, resp_pending, resp_drop}); else pass_cnt++;
  endtask

  initial begin
    tsf_pulse_1M = 1'b0; pkt_header_valid_strobe = 1'b0; pkt_header_valid = 1'b0;
    FC_DI_valid = 1'b0; FC_type = '0; FC_subtype = '0; duration = '0;
    addr1_valid = 1'b0; addr1 = '0; addr2_valid = 1'b0; addr2 = '0;
    self_mac_addr = SELF; fcs_in_strobe = 1'b0; fcs_valid = 1'b0;
    resp_enable = 1'b1; sifs_time = 7'd16; resp_time = 8'd44; resp_ack = 1'b0;
    test_reset();
    test_ack_data();
    test_cts_saturate();
    test_ineligible();
    test_sifs_abort();
    test_timeout();
    test_zero_sifs_and_enable();
    test_back_to_back();
    test_reset_in_req();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
